// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl
// Run-time sequencer for a variable power-of-two CIC decimator. A CPU
// decimation request is validated, held as pending, and applied only at an
// output-sample boundary. A timeout bounds how long that boundary wait may
// last. Each change flushes the CIC and hides the settling outputs, so
// downstream logic never sees samples from mixed or partially filled
// integrators.
//
// Ports
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   cfg_wr         one-cycle write strobe for cfg_decim
//   cfg_decim      requested decimation
//   cfg_err        one-cycle pulse when a request is rejected (registered)
//   cfg_busy       high when not in RUN or a request is pending (registered)
//   in_strobe      CIC input sample strobe
//   cic_out_strobe CIC output strobe
//   cic_reset      active-high flush to the CIC (registered)
//   decimation     decimation currently applied to the CIC (registered)
//   out_strobe     gated output strobe to downstream (zero added latency)
//   cur_decim_log2 log2 of the applied decimation (registered)
module cic_decim_ctrl #(
    parameter int MD            = 18,
    parameter int MAX_DECIM     = 2048,
    parameter int DEFAULT_DECIM = 256,
    parameter int STAGES        = 5,
    parameter int FLUSH_CYC     = 4,
    parameter int TIMEOUT_MULT  = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cfg_wr,
    input  logic [MD-1:0] cfg_decim,
    output logic          cfg_err,
    output logic          cfg_busy,
    input  logic          in_strobe,
    input  logic          cic_out_strobe,
    output logic          cic_reset,
    output logic [MD-1:0] decimation,
    output logic          out_strobe,
    output logic [4:0]    cur_decim_log2
);

    localparam int TW   = MD + 2;
    localparam int FC_W = $clog2(FLUSH_CYC + 1);
    localparam int SC_W = $clog2(STAGES + 1);
    localparam logic [4:0] DEF_LOG2 = 5'($clog2(DEFAULT_DECIM));

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    // Non-zero power of two no larger than the biggest supported decimation.
    function automatic logic is_legal(input logic [MD-1:0] v);
        return (v != {MD{1'b0}}) &&
               ((v & (v - MD'(1))) == {MD{1'b0}}) &&
               (v <= MD'(MAX_DECIM));
    endfunction

    // Index of the highest set bit; exact log2 for the power-of-two values stored.
    function automatic logic [4:0] log2_of(input logic [MD-1:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < MD; i++) begin
            r = v[i] ? 5'(i) : r;
        end
        return r;
    endfunction

    state_t          state_r, state_next_s;
    logic [FC_W-1:0] flush_cnt_r;
    logic [SC_W-1:0] settle_cnt_r;
    logic [TW-1:0]   tmo_cnt_r;
    logic [TW-1:0]   tmo_inc_s;
    logic [TW-1:0]   tmo_limit_s;
    logic [MD-1:0]   pend_decim_r;
    logic            pend_valid_r;
    logic            pend_valid_next_s;
    logic            busy_next_s;
    logic [MD-1:0]   decimation_r;
    logic [4:0]      log2_r;
    logic            cic_reset_r;
    logic            cfg_err_r;
    logic            cfg_busy_r;
    logic            pass_r;
    logic            legal_s;
    logic            same_s;
    logic            load_s;
    logic            reject_s;
    logic            apply_s;

    // Request decode and timeout arithmetic.
    always_comb begin
        legal_s  = is_legal(cfg_decim);
        // Re-requesting the value already in force while idle is a no-op.
        same_s   = (cfg_decim == decimation_r) && (state_r == ST_RUN) && !pend_valid_r;
        load_s   = cfg_wr && legal_s && !same_s;
        reject_s = cfg_wr && !legal_s;
        tmo_limit_s = TW'(TIMEOUT_MULT) * TW'(decimation_r);
        if (in_strobe && (tmo_cnt_r != {TW{1'b1}})) begin
            tmo_inc_s = tmo_cnt_r + TW'(1);
        end else begin
            tmo_inc_s = tmo_cnt_r;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_FLUSH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (pend_valid_r) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                // Switch on a real sample boundary, or give up waiting once the
                // count of input strobes (including this one) hits the limit.
                if (cic_out_strobe || (tmo_inc_s >= tmo_limit_s)) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == FC_W'(FLUSH_CYC - 1)) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_FLUSH;
                end
            end
            ST_SETTLE: begin
                if (cic_out_strobe && (settle_cnt_r == SC_W'(STAGES - 1))) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            default: begin
                state_next_s = ST_FLUSH;
            end
        endcase
    end

    // Output decode plus next values feeding the registered status outputs.
    always_comb begin
        apply_s    = (state_r == ST_WAIT) && (state_next_s == ST_FLUSH);
        out_strobe = cic_out_strobe & pass_r;
        // A write on the apply edge becomes the new pending request.
        if (load_s) begin
            pend_valid_next_s = 1'b1;
        end else if (apply_s) begin
            pend_valid_next_s = 1'b0;
        end else begin
            pend_valid_next_s = pend_valid_r;
        end
        busy_next_s = (state_next_s != ST_RUN) | pend_valid_next_s;
    end

    // Flush, settle and timeout counters; each is cleared outside its own state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt_r  <= {FC_W{1'b0}};
            settle_cnt_r <= {SC_W{1'b0}};
            tmo_cnt_r    <= {TW{1'b0}};
        end else begin
            if ((state_r == ST_FLUSH) && (state_next_s == ST_FLUSH)) begin
                flush_cnt_r <= flush_cnt_r + FC_W'(1);
            end else begin
                flush_cnt_r <= {FC_W{1'b0}};
            end
            if (state_r != ST_SETTLE) begin
                settle_cnt_r <= {SC_W{1'b0}};
            end else if (cic_out_strobe) begin
                settle_cnt_r <= settle_cnt_r + SC_W'(1);
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
            if (state_r == ST_WAIT) begin
                tmo_cnt_r <= tmo_inc_s;
            end else begin
                tmo_cnt_r <= {TW{1'b0}};
            end
        end
    end

    // Pending request register; the latest legal write wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_decim_r <= {MD{1'b0}};
            pend_valid_r <= 1'b0;
        end else begin
            if (load_s) begin
                pend_decim_r <= cfg_decim;
            end else begin
                pend_decim_r <= pend_decim_r;
            end
            pend_valid_r <= pend_valid_next_s;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            decimation_r <= MD'(DEFAULT_DECIM);
            log2_r       <= DEF_LOG2;
            cic_reset_r  <= 1'b1;
            cfg_err_r    <= 1'b0;
            cfg_busy_r   <= 1'b1;
            pass_r       <= 1'b0;
        end else begin
            if (apply_s) begin
                decimation_r <= pend_decim_r;
                log2_r       <= log2_of(pend_decim_r);
            end else begin
                decimation_r <= decimation_r;
                log2_r       <= log2_r;
            end
            cic_reset_r <= (state_next_s == ST_FLUSH);
            cfg_err_r   <= reject_s;
            cfg_busy_r  <= busy_next_s;
            pass_r      <= (state_next_s == ST_RUN) || (state_next_s == ST_WAIT);
        end
    end

    assign cic_reset      = cic_reset_r;
    assign decimation     = decimation_r;
    assign cur_decim_log2 = log2_r;
    assign cfg_err        = cfg_err_r;
    assign cfg_busy       = cfg_busy_r;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl. Expected out_strobe results are
// queued per driven cic_out_strobe pulse. Expected decimation values are
// queued per accepted request. A negedge monitor pops and compares both.
module tb_cic_decim_ctrl;
    localparam int MD = 18;

    logic          clock          = 1'b0;
    logic          reset_n        = 1'b0;
    logic          cfg_wr         = 1'b0;
    logic [MD-1:0] cfg_decim      = 18'd0;
    logic          in_strobe      = 1'b0;
    logic          cic_out_strobe = 1'b0;
    logic          cfg_err;
    logic          cfg_busy;
    logic          cic_reset;
    logic [MD-1:0] decimation;
    logic          out_strobe;
    logic [4:0]    cur_decim_log2;

    int total = 0;
    int bad   = 0;
    bit            exp_pass_q[$];
    logic [MD-1:0] exp_dec_q[$];

    cic_decim_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cfg_wr         (cfg_wr),
        .cfg_decim      (cfg_decim),
        .cfg_err        (cfg_err),
        .cfg_busy       (cfg_busy),
        .in_strobe      (in_strobe),
        .cic_out_strobe (cic_out_strobe),
        .cic_reset      (cic_reset),
        .decimation     (decimation),
        .out_strobe     (out_strobe),
        .cur_decim_log2 (cur_decim_log2)
    );

    always #5 clock = ~clock;

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        logic [MD-1:0] prev_dec;
        logic [MD-1:0] exp_dec;
        bit            exp_pass;
        prev_dec = 18'd256;
        forever begin
            @(negedge clock);
            total++;
            if (cic_out_strobe === 1'b1) begin
                if (exp_pass_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected: cic_out_strobe with no expectation queued");
                end else begin
                    exp_pass = exp_pass_q.pop_front();
                    if (out_strobe !== exp_pass) begin
                        bad++;
                        $display("FAIL out_strobe: got %b want %b at %0t", out_strobe, exp_pass, $time);
                    end
                end
            end else if (out_strobe !== 1'b0) begin
                bad++;
                $display("FAIL idle_strobe: got %b want 0 at %0t", out_strobe, $time);
            end
            if (decimation !== prev_dec) begin
                total++;
                if (exp_dec_q.size() == 0) begin
                    bad++;
                    $display("FAIL dec_unexpected: got %0d, no change expected at %0t", decimation, $time);
                end else begin
                    exp_dec = exp_dec_q.pop_front();
                    if (decimation !== exp_dec) begin
                        bad++;
                        $display("FAIL dec_change: got %0d want %0d at %0t", decimation, exp_dec, $time);
                    end
                end
                prev_dec = decimation;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_out(input bit exp_pass, input int gap);
        cic_out_strobe = 1'b1;
        exp_pass_q.push_back(exp_pass);
        tick(1);
        cic_out_strobe = 1'b0;
        tick(gap);
    endtask

    task automatic write_cfg(input logic [MD-1:0] v);
        cfg_decim = v;
        cfg_wr    = 1'b1;
        tick(1);
        cfg_wr    = 1'b0;
    endtask

    // Counts falling edges with cic_reset high over the next six cycles.
    task automatic flush_len(output int n);
        n = 0;
        repeat (6) begin
            @(negedge clock);
            if (cic_reset === 1'b1) n++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic settle_seq();
        for (int i = 0; i < 5; i++) pulse_out(1'b0, 1);
        pulse_out(1'b1, 1);
    endtask

    task automatic test_reset();
        int n;
        tick(2);
        pulse_out(1'b0, 0);
        total++; if (cic_reset !== 1'b1) begin bad++; $display("FAIL rst_cic_reset: got %b want 1", cic_reset); end
        total++; if (decimation !== 18'd256) begin bad++; $display("FAIL rst_decim: got %0d want 256", decimation); end
        total++; if (cur_decim_log2 !== 5'd8) begin bad++; $display("FAIL rst_log2: got %0d want 8", cur_decim_log2); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", cfg_err); end
        total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", cfg_busy); end
        reset_n = 1'b1;
        flush_len(n);
        total++; if (n != 4) begin bad++; $display("FAIL rst_flush_len: got %0d want 4", n); end
        for (int i = 0; i < 4; i++) pulse_out(1'b0, 1);
        total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL settle_busy: got %b want 1", cfg_busy); end
        pulse_out(1'b0, 1);
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL run_busy: got %b want 0", cfg_busy); end
        pulse_out(1'b1, 1);
    endtask

    task automatic test_change();
        int n;
        exp_dec_q.push_back(18'd1024);
        write_cfg(18'd1024);
        total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL chg_busy: got %b want 1", cfg_busy); end
        total++; if (decimation !== 18'd256) begin bad++; $display("FAIL chg_early: got %0d want 256", decimation); end
        tick(3);
        total++; if (decimation !== 18'd256) begin bad++; $display("FAIL chg_wait_decim: got %0d want 256", decimation); end
        total++; if (cic_reset !== 1'b0) begin bad++; $display("FAIL chg_wait_reset: got %b want 0", cic_reset); end
        pulse_out(1'b1, 0);
        total++; if (cur_decim_log2 !== 5'd10) begin bad++; $display("FAIL chg_log2: got %0d want 10", cur_decim_log2); end
        flush_len(n);
        total++; if (n != 4) begin bad++; $display("FAIL chg_flush_len: got %0d want 4", n); end
        settle_seq();
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL chg_done_busy: got %b want 0", cfg_busy); end
    endtask

    task automatic test_illegal();
        logic [MD-1:0] vals [3];
        vals = '{18'd0, 18'd96, 18'd4096};
        for (int i = 0; i < 3; i++) begin
            write_cfg(vals[i]);
            total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL ill_err v=%0d: got %b want 1", vals[i], cfg_err); end
            total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL ill_busy v=%0d: got %b want 0", vals[i], cfg_busy); end
            total++; if (decimation !== 18'd1024) begin bad++; $display("FAIL ill_decim v=%0d: got %0d want 1024", vals[i], decimation); end
            tick(1);
            total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL ill_err_width v=%0d: got %b want 0", vals[i], cfg_err); end
        end
        write_cfg(18'd1024);
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL same_err: got %b want 0", cfg_err); end
        tick(3);
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL same_busy: got %b want 0", cfg_busy); end
    endtask

    task automatic test_timeout();
        int n;
        exp_dec_q.push_back(18'd256);
        write_cfg(18'd256);
        tick(3);
        pulse_out(1'b1, 0);
        flush_len(n);
        settle_seq();
        exp_dec_q.push_back(18'd128);
        write_cfg(18'd128);
        tick(1);
        in_strobe = 1'b1;
        tick(511);
        total++; if (cic_reset !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b want 0", cic_reset); end
        total++; if (decimation !== 18'd256) begin bad++; $display("FAIL tmo_early_decim: got %0d want 256", decimation); end
        tick(1);
        in_strobe = 1'b0;
        total++; if (cic_reset !== 1'b1) begin bad++; $display("FAIL tmo_flush: got %b want 1", cic_reset); end
        total++; if (cur_decim_log2 !== 5'd7) begin bad++; $display("FAIL tmo_log2: got %0d want 7", cur_decim_log2); end
        flush_len(n);
        total++; if (n != 4) begin bad++; $display("FAIL tmo_flush_len: got %0d want 4", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        pulse_out(1'b0, 1);
        pulse_out(1'b0, 1);
        write_cfg(18'd64);
        exp_dec_q.push_back(18'd32);
        write_cfg(18'd32);
        total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", cfg_busy); end
        for (int i = 0; i < 3; i++) pulse_out(1'b0, 1);
        total++; if (cfg_busy !== 1'b1) begin bad++; $display("FAIL b2b_run_busy: got %b want 1", cfg_busy); end
        total++; if (decimation !== 18'd128) begin bad++; $display("FAIL b2b_hold: got %0d want 128", decimation); end
        pulse_out(1'b1, 0);
        total++; if (cur_decim_log2 !== 5'd5) begin bad++; $display("FAIL b2b_log2: got %0d want 5", cur_decim_log2); end
        flush_len(n);
        total++; if (n != 4) begin bad++; $display("FAIL b2b_flush_len: got %0d want 4", n); end
        settle_seq();
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL b2b_done_busy: got %b want 0", cfg_busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        exp_dec_q.push_back(18'd1024);
        write_cfg(18'd1024);
        tick(3);
        pulse_out(1'b1, 0);
        tick(1);
        write_cfg(18'd512);
        exp_dec_q.push_back(18'd256);
        #1 reset_n = 1'b0;
        #1;
        total++; if (cic_reset !== 1'b1) begin bad++; $display("FAIL mid_cic_reset: got %b want 1", cic_reset); end
        total++; if (decimation !== 18'd256) begin bad++; $display("FAIL mid_decim: got %0d want 256", decimation); end
        total++; if (cur_decim_log2 !== 5'd8) begin bad++; $display("FAIL mid_log2: got %0d want 8", cur_decim_log2); end
        tick(2);
        reset_n = 1'b1;
        flush_len(n);
        total++; if (n != 4) begin bad++; $display("FAIL mid_flush_len: got %0d want 4", n); end
        settle_seq();
        tick(4);
        total++; if (cfg_busy !== 1'b0) begin bad++; $display("FAIL mid_pend_cleared: got %b want 0", cfg_busy); end
        total++; if (decimation !== 18'd256) begin bad++; $display("FAIL mid_final_decim: got %0d want 256", decimation); end
    endtask

    initial begin
        test_reset();
        test_change();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        tick(2);
        total++;
        if ((exp_pass_q.size() != 0) || (exp_dec_q.size() != 0)) begin
            bad++;
            $display("FAIL leftover: strobe_q=%0d dec_q=%0d want 0 0", exp_pass_q.size(), exp_dec_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
